sad_block_engine: RTL

Self-sequencing sum-of-absolute-differences engine for block matching. It works out its own addresses, walks a LEN-element block pair from synchronous-read memories and accumulates |a−b| at full precision. It reports the result with a start/done handshake and tracks the minimum SAD over successive runs. The engine needs no external controller and takes the place of the earlier externally sequenced SAD datapath in the motion-search pipeline.

---
 rtl/sad_if.sv | 30 +++
 rtl/sad_block_engine.sv | 100 ++++++++++
 2 files changed

// File: rtl/sad_if.sv
// sad_if: handshake and memory bus of sad_block_engine
// Parameters mirror the engine: DATA_W sample width, ADDR_W address width, ACC_W result width, RUN_W run-index width.
// slave modport is the engine side; master modport is the controller/memory side.
interface sad_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int ACC_W = 36,
  parameter int RUN_W = 8
) ();
  logic start;
  logic min_clr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] ab_addr;
  logic rd_en;
  logic busy;
  logic done;
  logic [ACC_W-1:0] sad;
  logic sat;
  logic [ACC_W-1:0] min_sad;
  logic [RUN_W-1:0] min_idx;
  modport slave (
    input start, min_clr, a_data, b_data,
    output ab_addr, rd_en, busy, done, sad, sat, min_sad, min_idx
  );
  modport master (
    output start, min_clr, a_data, b_data,
    input ab_addr, rd_en, busy, done, sad, sat, min_sad, min_idx
  );
endinterface

// File: rtl/sad_block_engine.sv
// sad_block_engine: self-sequencing sum-of-absolute-differences engine with minimum tracking
// Optional macro SAD_SAT_EN: accumulator clamps to all-ones and sat reports it; undefined wraps modulo 2^ACC_W and sat is 0.
// Ports: clk rising-edge clock; rst_n asynchronous active-low reset;
//   bus (sad_if.slave): start, min_clr, a_data, b_data in; ab_addr, rd_en, busy, done, sad, sat, min_sad, min_idx out.
module sad_block_engine #(
  parameter int DATA_W = 32,
  parameter int LEN = 8,
  parameter int ADDR_W = 9,
  parameter int ACC_W = 36,
  parameter int SIGNED = 1,
  parameter int RUN_W = 8
) (
  input logic clk,
  input logic rst_n,
  sad_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [ADDR_W-1:0] addr;
  logic rd, vld;
  logic [ACC_W-1:0] acc, acc_nxt, sad_q, min_q;
  logic [RUN_W-1:0] run_cnt, idx_q;
  logic [DATA_W:0] a_x, b_x, dif, mag;
  // one extra bit holds any difference of two DATA_W samples, so |a-b| never overflows
  assign a_x = SIGNED != 0 ? {bus.a_data[DATA_W-1], bus.a_data} : {1'b0, bus.a_data};
  assign b_x = SIGNED != 0 ? {bus.b_data[DATA_W-1], bus.b_data} : {1'b0, bus.b_data};
  assign dif = a_x - b_x;
  assign mag = dif[DATA_W] ? -dif : dif;
`ifdef SAD_SAT_EN
  logic c, sat_f, sat_q;
  logic [ACC_W-1:0] raw;
  assign {c, raw} = {1'b0, acc} + {1'b0, ACC_W'(mag)};
  assign acc_nxt = c ? '1 : raw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sat_f <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) sat_f <= 1'b0;
      else if (vld) sat_f <= sat_f | c;
      if (state == DRAIN) sat_q <= sat_f | c;
    end
  assign bus.sat = sat_q;
`else
  assign acc_nxt = acc + ACC_W'(mag);
  assign bus.sat = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      rd <= 1'b0;
      vld <= 1'b0;
      acc <= '0;
      sad_q <= '0;
      min_q <= '1;
      idx_q <= '0;
      run_cnt <= '0;
    end else begin
      // data for the address issued last cycle arrives now
      vld <= rd;
      if (vld) acc <= acc_nxt;
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          addr <= '0;
          rd <= 1'b1;
          acc <= '0;
        end
        RUN: if (addr == ADDR_W'(LEN - 1)) begin
          state <= DRAIN;
          rd <= 1'b0;
        end else addr <= addr + 1'b1;
        DRAIN: begin
          state <= DONE;
          sad_q <= acc_nxt;
        end
        default: begin
          state <= IDLE;
          run_cnt <= run_cnt + 1'b1;
          if (sad_q < min_q) begin
            min_q <= sad_q;
            idx_q <= run_cnt;
          end
        end
      endcase
      // a clear on the same edge as a DONE update takes priority
      if (bus.min_clr) begin
        min_q <= '1;
        idx_q <= '0;
      end
    end
  assign bus.ab_addr = addr;
  assign bus.rd_en = rd;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.sad = sad_q;
  assign bus.min_sad = min_q;
  assign bus.min_idx = idx_q;
endmodule
